fir_seq_ctrl: RTL

Control and scheduling block for the user-project FIR engine. It holds the ap_ctrl, data_length and tap-coefficient register window, and loads taps into the tap RAM. It clears the sample shift RAM at start, accepts X samples over AXI-Stream, and steps the shared MAC datapath through NTAP tap/data address pairs per sample. It returns each Y result on an AXI-Stream master. It sits between the Wishbone/AXI-Lite decode logic and the FIR MAC datapath plus its tap and data RAMs.

---
 rtl/fir_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fir_seq_ctrl.sv
// Sequencer for the FIR engine: holds the config window, loads taps, clears the
// sample RAM, then steps the shared MAC datapath once per input sample.
module fir_seq_ctrl #(
    parameter int DW     = 32,
    parameter int NTAP   = 11,
    parameter int IDXW   = 4,
    parameter int DP_LAT = 2
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cfg_we,
    input  logic            cfg_re,
    input  logic [11:0]     cfg_addr,
    input  logic [DW-1:0]   cfg_wdata,
    output logic [DW-1:0]   cfg_rdata,
    output logic            cfg_rvalid,
    input  logic            ss_tvalid,
    input  logic [DW-1:0]   ss_tdata,
    input  logic            ss_tlast,
    output logic            ss_tready,
    output logic            sm_tvalid,
    output logic [DW-1:0]   sm_tdata,
    output logic            sm_tlast,
    input  logic            sm_tready,
    output logic            tap_we,
    output logic [IDXW-1:0] tap_addr,
    output logic [DW-1:0]   tap_wdata,
    output logic            data_we,
    output logic [IDXW-1:0] data_addr,
    output logic [DW-1:0]   data_wdata,
    output logic            mac_en,
    output logic            mac_clr,
    input  logic [DW-1:0]   acc_in
);

    localparam int KW = (IDXW > $clog2(DP_LAT + 1)) ? IDXW : $clog2(DP_LAT + 1);
    localparam logic [11:0] TAP_END = 12'(64 + 4 * NTAP);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_WAIT_X, S_MAC, S_DRAIN, S_OUT, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [DW-1:0]   count_q, count_d;
    logic            last_flag_q, last_flag_d;
    logic            err_q, err_d;
    logic            ap_start_q, ap_start_d;
    logic            ap_done_q, ap_done_d;
    logic            ap_idle_q, ap_idle_d;
    logic [DW-1:0]   sm_tdata_q, sm_tdata_d;
    logic [DW-1:0]   data_length_q;
    logic [DW-1:0]   cfg_rdata_q;
    logic            cfg_rvalid_q;
    logic            tap_wr_q;
    logic [IDXW-1:0] tap_waddr_q;
    logic [DW-1:0]   tap_wdata_q;

    logic            is_ctrl_s, is_len_s, is_tap_s, start_s, tap_wr_s;
    logic [IDXW-1:0] tap_idx_s, k_idx_s, mac_daddr_s;

    assign is_ctrl_s = (cfg_addr == 12'h000);
    assign is_len_s  = (cfg_addr == 12'h010);
    assign is_tap_s  = (cfg_addr >= 12'h040) && (cfg_addr < TAP_END) && (cfg_addr[1:0] == 2'b00);
    assign tap_idx_s = IDXW'((cfg_addr - 12'h040) >> 2);
    assign start_s   = cfg_we && is_ctrl_s && cfg_wdata[0] && (state_q == S_IDLE);
    assign tap_wr_s  = cfg_we && is_tap_s && (state_q == S_IDLE);
    assign k_idx_s   = k_q[IDXW-1:0];
    // Circular sample index: true result is < NTAP, so modulo-2^IDXW wrap is harmless.
    assign mac_daddr_s = (ptr_q >= k_idx_s) ? (ptr_q - k_idx_s)
                                            : (ptr_q + IDXW'(NTAP) - k_idx_s);

    assign cfg_rdata  = cfg_rdata_q;
    assign cfg_rvalid = cfg_rvalid_q;
    assign sm_tdata   = sm_tdata_q;
    assign tap_we     = tap_wr_q;
    assign tap_wdata  = tap_wdata_q;

    // Sequencer next-state and datapath strobes.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        last_flag_d = last_flag_q;
        err_d       = err_q;
        ap_start_d  = 1'b0;
        ap_idle_d   = ap_idle_q;
        sm_tdata_d  = sm_tdata_q;
        ss_tready   = 1'b0;
        data_we     = 1'b0;
        data_addr   = {IDXW{1'b0}};
        data_wdata  = {DW{1'b0}};
        mac_en      = 1'b0;
        mac_clr     = 1'b0;
        tap_addr    = tap_waddr_q;
        sm_tvalid   = 1'b0;
        sm_tlast    = 1'b0;
        if (cfg_re && is_ctrl_s) begin
            ap_done_d = 1'b0;
        end else begin
            ap_done_d = ap_done_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    state_d    = S_CLR;
                    k_d        = {KW{1'b0}};
                    ap_start_d = 1'b1;
                    ap_idle_d  = 1'b0;
                    ap_done_d  = 1'b0;
                    err_d      = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR: begin
                data_we   = 1'b1;
                data_addr = k_idx_s;
                if (k_q == KW'(NTAP - 1)) begin
                    k_d     = {KW{1'b0}};
                    ptr_d   = {IDXW{1'b0}};
                    count_d = {DW{1'b0}};
                    state_d = (data_length_q == {DW{1'b0}}) ? S_DONE : S_WAIT_X;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_WAIT_X: begin
                ss_tready = 1'b1;
                if (ss_tvalid) begin
                    data_we     = 1'b1;
                    data_addr   = ptr_q;
                    data_wdata  = ss_tdata;
                    last_flag_d = (count_q == (data_length_q - DW'(1)));
                    if (ss_tlast != last_flag_d) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    k_d     = {KW{1'b0}};
                    state_d = S_MAC;
                end else begin
                    state_d = S_WAIT_X;
                end
            end
            S_MAC: begin
                mac_en    = 1'b1;
                mac_clr   = (k_q == {KW{1'b0}});
                tap_addr  = k_idx_s;
                data_addr = mac_daddr_s;
                if (k_q == KW'(NTAP - 1)) begin
                    k_d     = {KW{1'b0}};
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DRAIN: begin
                if (k_q == KW'(DP_LAT - 1)) begin
                    sm_tdata_d = acc_in;
                    k_d        = {KW{1'b0}};
                    state_d    = S_OUT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_OUT: begin
                sm_tvalid = 1'b1;
                sm_tlast  = last_flag_q;
                if (sm_tready) begin
                    ptr_d   = (ptr_q == IDXW'(NTAP - 1)) ? {IDXW{1'b0}} : (ptr_q + IDXW'(1));
                    count_d = count_q + DW'(1);
                    state_d = last_flag_q ? S_DONE : S_WAIT_X;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_DONE: begin
                ap_done_d = 1'b1;
                ap_idle_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and status registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            k_q         <= {KW{1'b0}};
            ptr_q       <= {IDXW{1'b0}};
            count_q     <= {DW{1'b0}};
            last_flag_q <= 1'b0;
            err_q       <= 1'b0;
            ap_start_q  <= 1'b0;
            ap_done_q   <= 1'b0;
            ap_idle_q   <= 1'b1;
            sm_tdata_q  <= {DW{1'b0}};
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            last_flag_q <= last_flag_d;
            err_q       <= err_d;
            ap_start_q  <= ap_start_d;
            ap_done_q   <= ap_done_d;
            ap_idle_q   <= ap_idle_d;
            sm_tdata_q  <= sm_tdata_d;
        end
    end

    // Config window: length register, read port and staged tap writes.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            data_length_q <= {DW{1'b0}};
            cfg_rdata_q   <= {DW{1'b0}};
            cfg_rvalid_q  <= 1'b0;
            tap_wr_q      <= 1'b0;
            tap_waddr_q   <= {IDXW{1'b0}};
            tap_wdata_q   <= {DW{1'b0}};
        end else begin
            if (cfg_we && is_len_s && (state_q == S_IDLE)) begin
                data_length_q <= cfg_wdata;
            end
            cfg_rvalid_q <= cfg_re;
            if (cfg_re && is_ctrl_s) begin
                cfg_rdata_q <= {{(DW-4){1'b0}}, err_q, ap_idle_q, ap_done_q, ap_start_q};
            end else if (cfg_re && is_len_s) begin
                cfg_rdata_q <= data_length_q;
            end else begin
                cfg_rdata_q <= {DW{1'b0}};
            end
            tap_wr_q <= tap_wr_s;
            if (tap_wr_s) begin
                tap_waddr_q <= tap_idx_s;
                tap_wdata_q <= cfg_wdata;
            end
        end
    end

endmodule
